lsu: RTL and testbench
======================

Name: lsu

Overview:
- Load/store unit between the single-cycle core's data-memory port and a word-wide, handshaked data bus.
- Latches the core's access (wem, rwmm, rwam, wdm) and drives a multi-cycle bus transaction.
- Stalls the core until the transaction completes, and returns aligned, sign- or zero-extended load data on rdm.
- Detects misaligned accesses, illegal access modes and bus timeouts.

Parameters:
- TIMEOUT, 255, maximum BUSY cycles waiting for mem_ready before the access is aborted with a fault (1..65535).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
- core_req  input  1  core presents a load/store this cycle.
- wem  input  1  1 = store, 0 = load.
- rwmm  input  3  access mode, funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- rwam  input  32  byte address.
- wdm  input  32  store data, right-aligned.
- rdm  output  32  extended load data, valid in DONE.
- stall  output  1  core must hold PC and all state this cycle.
- fault  output  1  one-cycle pulse: misaligned, illegal mode, or timeout.
- mem_req  output  1  bus request.
- mem_we  output  1  bus write.
- mem_addr  output  32  word address; bits [1:0] are always 00.
- mem_wdata  output  32  lane-replicated store data.
- mem_wstrb  output  4  byte enables; 0000 on reads.
- mem_ready  input  1  bus accepts or completes the request this cycle.
- mem_rdata  input  32  read word, valid when mem_ready = 1 and mem_we = 0.

Behaviour:
- FSM states: IDLE, BUSY, DONE. On reset the FSM enters IDLE.
- Registered outputs reset to 0: mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, rdm, timeout counter.
- While reset = 0, stall and fault are forced to 0.
- Legality check (combinational):
  - Mode 011, 110 or 111 is illegal.
  - H/HU require rwam[0] = 0.
  - W requires rwam[1:0] = 00.
  - Stores with mode 100 or 101 are illegal.
- IDLE, core_req = 1 and legal:
  - stall = 1 combinationally.
  - Latch mem_addr = {rwam[31:2], 00}, mem_we = wem, the mode and rwam[1:0].
  - Store data: B replicated to 4 lanes; H replicated to 2 lanes; W unchanged.
  - mem_wstrb: B gives 0001 << rwam[1:0]; H gives 0011 << {rwam[1], 0}; W gives 1111.
  - Next state BUSY.
- IDLE, core_req = 1 and illegal:
  - fault = 1 and stall = 0 this cycle.
  - No bus request, no write, rdm = 0, stay in IDLE.
- IDLE, core_req = 0: all outputs idle.
- BUSY:
  - mem_req = 1 and stall = 1; all mem_* outputs held stable.
  - Timeout counter increments each cycle mem_ready = 0.
  - On mem_ready = 1: a load captures the extracted lane into rdm, a store sets rdm = 0. Drop mem_req at the next edge; go to DONE.
  - If the counter reaches TIMEOUT with mem_ready still 0: drop mem_req, rdm = 0, go to DONE with a fault pending.
- Load extraction uses the latched rwam[1:0]:
  - B: sign-extend byte lane.
  - BU: zero-extend byte lane.
  - H: sign-extend half lane rwam[1].
  - HU: zero-extend half lane rwam[1].
  - W: full word.
- DONE:
  - stall = 0; rdm valid; fault = 1 only if a timeout is pending.
  - The core retires the instruction at this edge.
  - Next state IDLE unconditionally; core_req is ignored here, so the same instruction never re-issues.
  - Counter clears.
- Latency: a zero-wait-state bus (mem_ready = 1 on the first BUSY cycle) gives 2 stall cycles (IDLE, BUSY); the result is available in the third cycle.
- Reset mid-BUSY: mem_req = 0 at that edge, the transaction is abandoned and no fault is raised.
- rdm holds its value outside DONE until the next completion.

Test Plan:
- Load word, ready immediately: core_req = 1, wem = 0, rwmm = 010, rwam = 0x100, mem_rdata = 0xDEADBEEF → mem_addr = 0x100, mem_wstrb = 0000, stall high for 2 cycles, rdm = 0xDEADBEEF in DONE, fault = 0.
- Signed and unsigned byte loads: rwam = 0x103, mem_rdata = 0x80FF1234 → LB gives rdm = 0xFFFFFF80; LBU gives rdm = 0x00000080.
- Halfword store with wait states: rwmm = 001, rwam = 0x202, wdm = 0x0000ABCD, mem_ready after 3 cycles → mem_addr = 0x200, mem_wdata = 0xABCDABCD, mem_wstrb = 1100, mem_req stable for all 3 cycles, stall for 4 cycles.
- Misaligned access: LW at rwam = 0x101 → fault pulses 1 cycle, stall = 0, mem_req never asserted. Same result for SB with rwmm = 100.
- Timeout: TIMEOUT = 4, mem_ready held 0 → mem_req drops after 4 BUSY cycles, DONE shows rdm = 0 and fault = 1, FSM returns to IDLE.
- Reset in BUSY: reset = 0 for one edge → mem_req = 0, stall = 0 and rdm = 0 on the following cycle; a subsequent LW completes normally.

Source files
------------

// File: rtl/lsu.sv
// Load/store unit: latches one core data access, runs it on a handshaked word bus,
// stalls the core meanwhile and returns aligned, extended load data.
module lsu #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        core_req,
  input  logic        wem,
  input  logic [2:0]  rwmm,
  input  logic [31:0] rwam,
  input  logic [31:0] wdm,
  output logic [31:0] rdm,
  output logic        stall,
  output logic        fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_reg, state_next;
  logic [2:0]  mode_reg;
  logic [1:0]  offset_reg;
  logic [15:0] timeout_cnt_reg;
  logic        timeout_pending_reg;

  logic        access_legal;
  logic        accept;
  logic        timed_out;
  logic [31:0] wdata_next;
  logic [3:0]  wstrb_next;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  always_comb begin
    access_legal = 1'b1;
    case (rwmm)
      3'b011, 3'b110, 3'b111: access_legal = 1'b0;
      3'b001:                 access_legal = (rwam[0] == 1'b0);
      3'b101:                 access_legal = (rwam[0] == 1'b0) && !wem;
      3'b010:                 access_legal = (rwam[1:0] == 2'b00);
      3'b100:                 access_legal = !wem;
      default:                access_legal = 1'b1;
    endcase
  end

  assign accept    = (state_reg == IDLE) && core_req && access_legal;
  assign timed_out = (state_reg == BUSY) && !mem_ready &&
                     (timeout_cnt_reg == 16'(TIMEOUT - 1));

  // Each byte lane picks its source according to access size.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign wdata_next[gi*8 +: 8] = (rwmm[1:0] == 2'b00) ? wdm[7:0] :
                                     (rwmm[1:0] == 2'b01) ? wdm[(gi % 2)*8 +: 8] :
                                                            wdm[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    wstrb_next = 4'b0000;
    if (wem) begin
      case (rwmm[1:0])
        2'b00:   wstrb_next = 4'b0001 << rwam[1:0];
        2'b01:   wstrb_next = 4'b0011 << {rwam[1], 1'b0};
        default: wstrb_next = 4'b1111;
      endcase
    end
  end

  assign byte_sel = mem_rdata[{offset_reg, 3'b000} +: 8];
  assign half_sel = offset_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    case (mode_reg)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_data = {24'h0, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_data = {16'h0, half_sel};
      default: load_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = BUSY;
      BUSY:    if (mem_ready || timed_out) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    stall = 1'b0;
    fault = 1'b0;
    if (reset) begin
      case (state_reg)
        IDLE: begin
          stall = accept;
          fault = core_req && !access_legal;
        end
        BUSY:    stall = 1'b1;
        DONE:    fault = timeout_pending_reg;
        default: ;
      endcase
    end
  end

  // Bus-side registers stay frozen for the whole BUSY phase.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_req             <= 1'b0;
      mem_we              <= 1'b0;
      mem_addr            <= 32'h0;
      mem_wdata           <= 32'h0;
      mem_wstrb           <= 4'b0000;
      rdm                 <= 32'h0;
      mode_reg            <= 3'b000;
      offset_reg          <= 2'b00;
      timeout_cnt_reg     <= 16'h0;
      timeout_pending_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            mem_req    <= 1'b1;
            mem_we     <= wem;
            mem_addr   <= {rwam[31:2], 2'b00};
            mem_wdata  <= wdata_next;
            mem_wstrb  <= wstrb_next;
            mode_reg   <= rwmm;
            offset_reg <= rwam[1:0];
          end else if (core_req) begin
            rdm <= 32'h0;
          end
        end
        BUSY: begin
          if (mem_ready) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= 4'b0000;
            rdm       <= mem_we ? 32'h0 : load_data;
          end else if (timed_out) begin
            mem_req             <= 1'b0;
            mem_we              <= 1'b0;
            mem_wstrb           <= 4'b0000;
            rdm                 <= 32'h0;
            timeout_pending_reg <= 1'b1;
            timeout_cnt_reg     <= timeout_cnt_reg + 16'h1;
          end else begin
            timeout_cnt_reg <= timeout_cnt_reg + 16'h1;
          end
        end
        DONE: begin
          timeout_cnt_reg     <= 16'h0;
          timeout_pending_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed table-driven bench for lsu with TIMEOUT = 4, plus reset sequences.
module tb_lsu;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        core_req = 1'b0;
  logic        wem = 1'b0;
  logic [2:0]  rwmm = 3'b000;
  logic [31:0] rwam = 32'h0;
  logic [31:0] wdm = 32'h0;
  logic [31:0] rdm;
  logic        stall, fault, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  int checks = 0;
  int errors = 0;

  lsu #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .core_req(core_req), .wem(wem), .rwmm(rwmm),
    .rwam(rwam), .wdm(wdm), .rdm(rdm), .stall(stall), .fault(fault),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        legal;
    logic        we;
    logic [2:0]  mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;      // BUSY cycles with mem_ready low before it rises
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_rdm;
    logic        exp_fault;
    int          exp_busy;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int busy;
    int stalls;
    bit done;
    @(posedge clk); #1;
    core_req = 1'b1; wem = v.we; rwmm = v.mode; rwam = v.addr; wdm = v.wdata;
    mem_ready = 1'b0; mem_rdata = v.rdata;
    @(negedge clk);
    if (!v.legal) begin
      chk({v.name, " stall"}, 32'(stall), 32'd0);
      chk({v.name, " fault"}, 32'(fault), 32'd1);
      chk({v.name, " mem_req"}, 32'(mem_req), 32'd0);
      @(posedge clk); #1; core_req = 1'b0;
      @(negedge clk);
      chk({v.name, " fault_pulse"}, 32'(fault), 32'd0);
      chk({v.name, " mem_req_after"}, 32'(mem_req), 32'd0);
      $display("txn %s: illegal, fault pulse", v.name);
      return;
    end
    chk({v.name, " stall_idle"}, 32'(stall), 32'd1);
    chk({v.name, " fault_idle"}, 32'(fault), 32'd0);
    busy = 0; stalls = 1; done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(posedge clk); #1;
      mem_ready = (busy == v.delay);
      @(negedge clk);
      if (stall) begin
        stalls++;
        chk({v.name, " mem_req"}, 32'(mem_req), 32'd1);
        chk({v.name, " mem_we"}, 32'(mem_we), 32'(v.we));
        chk({v.name, " mem_addr"}, mem_addr, v.exp_addr);
        chk({v.name, " mem_wdata"}, mem_wdata, v.exp_wdata);
        chk({v.name, " mem_wstrb"}, 32'(mem_wstrb), 32'(v.exp_wstrb));
        busy++;
      end else begin
        done = 1;
        chk({v.name, " mem_req_done"}, 32'(mem_req), 32'd0);
        chk({v.name, " rdm"}, rdm, v.exp_rdm);
        chk({v.name, " fault_done"}, 32'(fault), 32'(v.exp_fault));
      end
    end
    if (!done) chk({v.name, " done_reached"}, 32'd0, 32'd1);
    chk({v.name, " busy_cycles"}, 32'(busy), 32'(v.exp_busy));
    chk({v.name, " stall_cycles"}, 32'(stalls), 32'(v.exp_busy + 1));
    @(posedge clk); #1; core_req = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    chk({v.name, " no_reissue"}, 32'(mem_req), 32'd0);
    chk({v.name, " stall_after"}, 32'(stall), 32'd0);
    chk({v.name, " fault_after"}, 32'(fault), 32'd0);
    chk({v.name, " rdm_hold"}, rdm, v.exp_rdm);
    $display("txn %s: addr=0x%08h busy=%0d rdm=0x%08h", v.name, v.addr, busy, rdm);
  endtask

  vec_t vecs[$];
  vec_t lw_a, lw_b;

  initial begin
    //           name         legal we mode    addr        wdata         rdata       dly exp_addr   exp_wdata     wstrb    exp_rdm       flt busy
    vecs.push_back('{"LW_100",   1, 0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 0, 32'h100, 32'h0,        4'b0000, 32'hDEADBEEF, 0, 1});
    vecs.push_back('{"LB_103",   1, 0, 3'b000, 32'h103, 32'h0,        32'h80FF1234, 0, 32'h100, 32'h0,        4'b0000, 32'hFFFFFF80, 0, 1});
    vecs.push_back('{"LBU_103",  1, 0, 3'b100, 32'h103, 32'h0,        32'h80FF1234, 0, 32'h100, 32'h0,        4'b0000, 32'h00000080, 0, 1});
    vecs.push_back('{"SH_202",   1, 1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0,        2, 32'h200, 32'hABCDABCD, 4'b1100, 32'h0,        0, 3});
    vecs.push_back('{"LH_102",   1, 0, 3'b001, 32'h102, 32'h0,        32'h80FF1234, 1, 32'h100, 32'h0,        4'b0000, 32'hFFFF80FF, 0, 2});
    vecs.push_back('{"LHU_100",  1, 0, 3'b101, 32'h100, 32'h0,        32'h80FF9234, 3, 32'h100, 32'h0,        4'b0000, 32'h00009234, 0, 4});
    vecs.push_back('{"SB_101",   1, 1, 3'b000, 32'h101, 32'h123456A5, 32'h0,        0, 32'h100, 32'hA5A5A5A5, 4'b0010, 32'h0,        0, 1});
    vecs.push_back('{"SW_104",   1, 1, 3'b010, 32'h104, 32'hCAFEF00D, 32'h0,        1, 32'h104, 32'hCAFEF00D, 4'b1111, 32'h0,        0, 2});
    vecs.push_back('{"LB_102",   1, 0, 3'b000, 32'h102, 32'h0,        32'h007F0000, 0, 32'h100, 32'h0,        4'b0000, 32'h0000007F, 0, 1});
    vecs.push_back('{"LW_101",   0, 0, 3'b010, 32'h101, 32'h0,        32'h0,        0, 32'h0,   32'h0,        4'b0000, 32'h0,        1, 0});
    vecs.push_back('{"SBU_100",  0, 1, 3'b100, 32'h100, 32'h55,       32'h0,        0, 32'h0,   32'h0,        4'b0000, 32'h0,        1, 0});
    vecs.push_back('{"MODE_011", 0, 0, 3'b011, 32'h100, 32'h0,        32'h0,        0, 32'h0,   32'h0,        4'b0000, 32'h0,        1, 0});
    vecs.push_back('{"LH_103",   0, 0, 3'b001, 32'h103, 32'h0,        32'h0,        0, 32'h0,   32'h0,        4'b0000, 32'h0,        1, 0});
    vecs.push_back('{"LW_TMO",   1, 0, 3'b010, 32'h300, 32'h0,        32'h12345678, 99, 32'h300, 32'h0,       4'b0000, 32'h0,        1, 4});
    lw_a = '{"LW_010",  1, 0, 3'b010, 32'h010, 32'h0, 32'h55AA55AA, 0, 32'h010, 32'h0, 4'b0000, 32'h55AA55AA, 0, 1};
    lw_b = '{"LW_404",  1, 0, 3'b010, 32'h404, 32'h0, 32'h0BADF00D, 1, 32'h404, 32'h0, 4'b0000, 32'h0BADF00D, 0, 2};

    // Reset held with an illegal request present: stall and fault stay low.
    core_req = 1'b1; rwmm = 3'b111; rwam = 32'h3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst stall", 32'(stall), 32'd0);
    chk("rst fault", 32'(fault), 32'd0);
    chk("rst mem_req", 32'(mem_req), 32'd0);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst rdm", rdm, 32'h0);
    $display("txn reset: outputs idle");
    core_req = 1'b0;
    @(posedge clk); #1; reset = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset mid-BUSY abandons the access without a fault.
    run_vec(lw_a);
    @(posedge clk); #1;
    core_req = 1'b1; wem = 1'b0; rwmm = 3'b010; rwam = 32'h400; mem_ready = 1'b0;
    @(negedge clk);
    chk("rstbusy stall_idle", 32'(stall), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstbusy mem_req", 32'(mem_req), 32'd1);
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk("rstbusy stall_forced", 32'(stall), 32'd0);
    chk("rstbusy fault_forced", 32'(fault), 32'd0);
    @(posedge clk); #1; reset = 1'b1; core_req = 1'b0;
    @(negedge clk);
    chk("rstbusy mem_req_after", 32'(mem_req), 32'd0);
    chk("rstbusy stall_after", 32'(stall), 32'd0);
    chk("rstbusy fault_after", 32'(fault), 32'd0);
    chk("rstbusy rdm_after", rdm, 32'h0);
    $display("txn reset_in_busy: access abandoned");
    run_vec(lw_b);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
